// File: rtl/mmem_pipe_ctrl.sv
// Main-memory block: masked simple dual-port word array, pipelined reads into a
// credit-controlled output FIFO, and a hardware clear sequencer.
module mmem_pipe_ctrl #(
  parameter int DATA_WDT   = 64,
  parameter int LANE_CNT   = 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WDT   = $clog2(MEM_DEPTH),
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [ADDR_WDT-1:0] rd_addr,
  output logic                rd_step,
  input  logic                mmem_rd_clk_en,
  output logic [DATA_WDT-1:0] data_out,
  output logic                data_out_val,
  input  logic                wr_en,
  input  logic [ADDR_WDT-1:0] wr_addr,
  input  logic [DATA_WDT-1:0] data_in,
  input  logic [LANE_CNT-1:0] wr_mask,
  input  logic                mmem_wr_clk_en,
  output logic                wr_step,
  input  logic                clr_start,
  output logic                busy
);
  localparam int LANE_WDT  = DATA_WDT / LANE_CNT;
  localparam int CNT_WDT   = $clog2(FIFO_DEPTH + 1);
  localparam int BUF_DEPTH = FIFO_DEPTH - 1;
  localparam int PTR_WDT   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  if (RD_LAT < 1) begin : g_lat_chk
    $error("RD_LAT must be at least 1");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_fifo_chk
    $error("FIFO_DEPTH must be at least RD_LAT+2");
  end
  if (DATA_WDT % LANE_CNT != 0) begin : g_lane_chk
    $error("DATA_WDT must be a multiple of LANE_CNT");
  end

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WDT-1:0] clr_idx_q;
  logic [CNT_WDT-1:0]  cnt_q, inflight_q, buf_cnt_q;
  logic                rd_acc, wr_acc, pop, push;
  logic                rd_in_range, wr_in_range;
  logic [DATA_WDT-1:0] push_data;
  logic                head_free, buf_pop, buf_push;

  assign rd_in_range = 32'(rd_addr) < 32'(MEM_DEPTH);
  assign wr_in_range = 32'(wr_addr) < 32'(MEM_DEPTH);

  assign wr_step = (state_q == IDLE);
  assign rd_step = (state_q == IDLE) && (cnt_q < CNT_WDT'(FIFO_DEPTH));
  assign busy    = (state_q != IDLE);
  assign rd_acc  = rd_en & rd_step;
  assign wr_acc  = wr_en & mmem_wr_clk_en & wr_step;
  assign pop     = data_out_val & mmem_rd_clk_en;

  // ---------------------------------------------------------------- storage
  logic [DATA_WDT-1:0] mem [MEM_DEPTH];

  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // zeroing it is the job of the clear sequencer.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_acc && wr_in_range) begin
      for (int i = 0; i < LANE_CNT; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*LANE_WDT +: LANE_WDT] <= data_in[i*LANE_WDT +: LANE_WDT];
      end
    end
  end

  // ---------------------------------------------------------- read pipeline
  logic [RD_LAT-1:0]   pipe_val_q;
  logic [DATA_WDT-1:0] pipe_data_q [RD_LAT];

  // NOTE: non-blocking assignments make a same-address write land after this
  // sample, so a colliding read returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_val_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_data_q[k] <= '0;
    end else begin
      pipe_val_q[0]  <= rd_acc;
      pipe_data_q[0] <= (rd_acc && rd_in_range) ? mem[rd_addr] : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_val_q[k]  <= pipe_val_q[k-1];
        pipe_data_q[k] <= pipe_data_q[k-1];
      end
    end
  end

  assign push      = pipe_val_q[RD_LAT-1];
  assign push_data = pipe_data_q[RD_LAT-1];

  // Credits cover both in-flight reads and FIFO occupancy, so a push always has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      cnt_q      <= cnt_q + CNT_WDT'(rd_acc) - CNT_WDT'(pop);
      inflight_q <= inflight_q + CNT_WDT'(rd_acc) - CNT_WDT'(push);
    end
  end

  // ------------------------------------------------------------ output FIFO
  // Registered head (data_out) backed by a small ring buffer.
  logic [DATA_WDT-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_WDT-1:0]  buf_rd_q, buf_wr_q;

  function automatic logic [PTR_WDT-1:0] ptr_inc(input logic [PTR_WDT-1:0] p);
    return (p == PTR_WDT'(BUF_DEPTH - 1)) ? '0 : p + PTR_WDT'(1);
  endfunction

  assign head_free = !data_out_val || pop;
  assign buf_pop   = head_free && (buf_cnt_q != '0);
  assign buf_push  = push && !(head_free && (buf_cnt_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      data_out_val <= 1'b0;
    end else if (head_free) begin
      if (buf_pop) begin
        data_out     <= buf_mem[buf_rd_q];
        data_out_val <= 1'b1;
      end else if (push) begin
        data_out     <= push_data;
        data_out_val <= 1'b1;
      end else begin
        data_out_val <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_rd_q  <= '0;
      buf_wr_q  <= '0;
      buf_cnt_q <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) buf_mem[k] <= '0;
    end else begin
      if (buf_push) begin
        buf_mem[buf_wr_q] <= push_data;
        buf_wr_q          <= ptr_inc(buf_wr_q);
      end
      if (buf_pop) buf_rd_q <= ptr_inc(buf_rd_q);
      buf_cnt_q <= buf_cnt_q + CNT_WDT'(buf_push) - CNT_WDT'(buf_pop);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && !buf_pop && (buf_cnt_q == CNT_WDT'(BUF_DEPTH))));

  // ---------------------------------------------------------- clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= (state_q == CLEAR) ? clr_idx_q + ADDR_WDT'(1) : '0;
    end
  end

  // NOTE: state_d takes its default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_start) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0) state_d = CLEAR;
      CLEAR:   if (clr_idx_q == ADDR_WDT'(MEM_DEPTH - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
